// File: rtl/romulus_pkg.sv
// Shared definitions for the Romulus TBC sequencer: FSM encoding,
// the SKINNY-128-384+ round-constant LFSR step and the default round count.
package romulus_pkg;

    // Round count of one SKINNY-128-384+ call.
    localparam int ROUNDS_DEFAULT = 40;

    // Sequencer states. The encoding is visible on the top-level state_dbg port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROUND   = 2'd1,
        ST_CORRECT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One step of the 6-bit round-constant LFSR: shift left, feed back rc5^rc4^1.
    function automatic logic [5:0] rc_step(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

    // Apply rc_step n times. Loop bound is a constant at every call site.
    function automatic logic [5:0] rc_advance(input logic [5:0] rc, input int n);
        logic [5:0] v;
        v = rc;
        for (int i = 0; i < n; i++) begin
            v = rc_step(v);
        end
        return v;
    endfunction

endpackage

// File: rtl/romulus_rc_lfsr.sv
// Round-constant generator: a 6-bit LFSR register that presents the
// constants of RPC consecutive rounds and advances RPC steps per enable.
module romulus_rc_lfsr
    import romulus_pkg::*;
#(
    parameter int RPC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             adv,
    output logic [6*RPC-1:0] rc_vec
);

    logic [5:0] rc_q;

    // Register: cleared by reset, seeded with 01 at call start, stepped RPC times per round cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rc_q <= 6'h00;
        end else if (load) begin
            rc_q <= 6'h01;
        end else if (adv) begin
            rc_q <= rc_advance(rc_q, RPC);
        end
    end

    // Lane i carries the constant of the i-th round within the current cycle.
    always_comb begin
        rc_vec = '0;
        for (int i = 0; i < RPC; i++) begin
            rc_vec[6*i +: 6] = rc_advance(rc_q, i);
        end
    end

endmodule

// File: rtl/romulus_tbc_sequencer.sv
// Control sequencer for one SKINNY-128-384+ TBC call in Romulus:
// IDLE -> ROUND (ROUNDS/RPC cycles) -> CORRECT (1 cycle) -> DONE (1 cycle) -> IDLE.
//
// Handshake: start is a request sampled only while ready=1 (state IDLE); a
// request seen in that cycle is accepted at the clock edge, together with
// cnt_corr. start is ignored at any other time. done pulses for exactly one
// cycle when the call completes; ready returns the cycle after done, so a
// start held high starts the next call with no gap cycle.
//
// Every output is decoded from registered state only; start and cnt_corr
// reach no output combinationally.
module romulus_tbc_sequencer
    import romulus_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT,
    parameter int RPC    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cnt_corr,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [6*RPC-1:0] constant,
    output logic             sen,
    output logic             senc,
    output logic             xen,
    output logic             xenc,
    output logic             yen,
    output logic             yenc,
    output logic             zen,
    output logic             zenc,
    output logic             correct_cnt,
    output logic [5:0]       round,
    output logic [1:0]       state_dbg
);

    // Round index of the final ROUND cycle.
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - RPC);
    localparam logic [5:0] ROUND_STEP = 6'(RPC);

    state_t            state_q;
    state_t            state_d;
    logic [5:0]        round_q;
    logic              corr_q;
    logic              rc_load;
    logic              rc_adv;
    logic              last_round;
    logic [6*RPC-1:0]  rc_vec;

    assign last_round = (round_q == LAST_ROUND);

    romulus_rc_lfsr #(
        .RPC (RPC)
    ) u_rc_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (rc_load),
        .adv    (rc_adv),
        .rc_vec (rc_vec)
    );

    // State register; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded enables/status.
    always_comb begin
        state_d     = state_q;
        rc_load     = 1'b0;
        rc_adv      = 1'b0;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        sen         = 1'b0;
        senc        = 1'b0;
        xen         = 1'b0;
        xenc        = 1'b0;
        yen         = 1'b0;
        yenc        = 1'b0;
        zen         = 1'b0;
        zenc        = 1'b0;
        correct_cnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = ST_ROUND;
                    rc_load = 1'b1;
                end
            end
            ST_ROUND: begin
                busy   = 1'b1;
                sen    = 1'b1;
                senc   = 1'b1;
                xen    = 1'b1;
                xenc   = 1'b1;
                yen    = 1'b1;
                yenc   = 1'b1;
                zen    = 1'b1;
                zenc   = 1'b1;
                rc_adv = 1'b1;
                if (last_round) begin
                    state_d = ST_CORRECT;
                end
            end
            ST_CORRECT: begin
                // Tweakey update only; the TBC selects stay off.
                busy        = 1'b1;
                xen         = 1'b1;
                yen         = 1'b1;
                zen         = 1'b1;
                correct_cnt = corr_q;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Round index: counts by RPC through ROUND and rests at 0 everywhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= 6'd0;
        end else if (state_q == ST_ROUND && !last_round) begin
            round_q <= round_q + ROUND_STEP;
        end else begin
            round_q <= 6'd0;
        end
    end

    // Counter-correction select, captured when a call is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            corr_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            corr_q <= cnt_corr;
        end
    end

    assign constant  = (state_q == ST_ROUND) ? rc_vec : '0;
    assign round     = round_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_romulus_tbc_sequencer.sv
// Directed bench for romulus_tbc_sequencer with one RPC=1 and one RPC=2 instance.
module tb_romulus_tbc_sequencer;

    logic clk = 1'b0;
    logic rst;

    logic start1, cc1, ready1, busy1, done1, sen1, senc1, xen1, xenc1, yen1, yenc1, zen1, zenc1, corr1;
    logic [5:0]  constant1, round1;
    logic [1:0]  st1;

    logic start2, cc2, ready2, busy2, done2, sen2, senc2, xen2, xenc2, yen2, yenc2, zen2, zenc2, corr2;
    logic [11:0] constant2;
    logic [5:0]  round2;
    logic [1:0]  st2;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    // Expected {round, constant} per ROUND cycle.
    logic [11:0] exp_q1[$];
    logic [17:0] exp_q2[$];

    // Per-run observations.
    int          t_done, n_done, n_sen, n_corr, n_early;
    logic        r_last;
    logic [11:0] first_c, last_c;
    int          done_t[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    romulus_tbc_sequencer #(.ROUNDS(40), .RPC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .cnt_corr(cc1),
        .ready(ready1), .busy(busy1), .done(done1), .constant(constant1),
        .sen(sen1), .senc(senc1), .xen(xen1), .xenc(xenc1),
        .yen(yen1), .yenc(yenc1), .zen(zen1), .zenc(zenc1),
        .correct_cnt(corr1), .round(round1), .state_dbg(st1)
    );

    romulus_tbc_sequencer #(.ROUNDS(40), .RPC(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .cnt_corr(cc2),
        .ready(ready2), .busy(busy2), .done(done2), .constant(constant2),
        .sen(sen2), .senc(senc2), .xen(xen2), .xenc(xenc2),
        .yen(yen2), .yenc(yenc2), .zen(zen2), .zenc(zenc2),
        .correct_cnt(corr2), .round(round2), .state_dbg(st2)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] mdl_next(input logic [5:0] x);
        return {x[4:0], ~(x[5] ^ x[4])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1();
        logic [5:0] rc;
        rc = 6'h01;
        for (int i = 0; i < 40; i++) begin
            exp_q1.push_back({6'(i), rc});
            rc = mdl_next(rc);
        end
    endtask

    task automatic push2();
        logic [5:0] rc, nx;
        rc = 6'h01;
        for (int i = 0; i < 20; i++) begin
            nx = mdl_next(rc);
            exp_q2.push_back({6'(2 * i), nx, rc});
            rc = mdl_next(nx);
        end
    endtask

    // Runs `budget` cycles on one instance. start stays high while t < hold_until,
    // plus one extra pulse after cycle pulse_at; cnt_corr drops after the first edge.
    task automatic run_dut(input int which, input int budget, input int hold_until, input int pulse_at);
        logic d, s, c, r;
        logic [11:0] k;
        t_done = 0; n_done = 0; n_sen = 0; n_corr = 0; n_early = 0;
        first_c = '0; last_c = '0; r_last = 1'b0;
        done_t.delete();
        for (int t = 1; t <= budget; t++) begin
            tick();
            if (which == 1) begin
                start1 = (t < hold_until) || (t == pulse_at);
                cc1 = 1'b0;
                d = done1; s = sen1; c = corr1; r = ready1; k = {6'd0, constant1};
            end else begin
                start2 = (t < hold_until) || (t == pulse_at);
                cc2 = 1'b0;
                d = done2; s = sen2; c = corr2; r = ready2; k = constant2;
            end
            if (s) begin
                if (n_sen == 0) first_c = k;
                last_c = k;
                n_sen++;
            end
            if (c) n_corr++;
            if (r && n_done == 0) n_early++;
            if (d) begin
                n_done++;
                done_t.push_back(t);
                if (t_done == 0) t_done = t;
            end
            r_last = r;
        end
    endtask

    // ---------------- scoreboard / invariant monitor ----------------
    always @(negedge clk) begin
        logic [11:0] e1;
        logic [17:0] e2;
        if (mon_on) begin
            if (sen1) begin
                if (exp_q1.size() == 0) begin
                    check("rpc1_extra_round", 32'd1, 32'd0);
                end else begin
                    e1 = exp_q1.pop_front();
                    check("rpc1_round_const", {20'd0, round1, constant1}, {20'd0, e1});
                    check("rpc1_round_corr", {31'd0, corr1}, 32'd0);
                end
            end
            if (sen2) begin
                if (exp_q2.size() == 0) begin
                    check("rpc2_extra_round", 32'd1, 32'd0);
                end else begin
                    e2 = exp_q2.pop_front();
                    check("rpc2_round_const", {14'd0, round2, constant2}, {14'd0, e2});
                end
            end
            if (!busy1) begin
                check("rpc1_idle_quiet",
                      {12'd0, sen1, senc1, xen1, xenc1, yen1, yenc1, zen1, zenc1, corr1, round1, constant1}, 32'd0);
            end else if (!sen1) begin
                check("rpc1_correct_en", {24'd0, senc1, xen1, xenc1, yen1, yenc1, zen1, zenc1, round1 == 6'd0},
                      {24'd0, 8'b01010101});
            end
            if (!busy2) begin
                check("rpc2_idle_quiet",
                      {6'd0, sen2, senc2, xen2, xenc2, yen2, yenc2, zen2, zenc2, corr2, round2, constant2}, 32'd0);
            end
            check("rpc1_done_busy_excl", {31'd0, done1 & busy1}, 32'd0);
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        start1 = 1'b0; cc1 = 1'b0; start2 = 1'b0; cc2 = 1'b0;
        repeat (3) tick();

        // Reset state, with start asserted to show reset priority.
        start1 = 1'b1; start2 = 1'b1;
        tick();
        start1 = 1'b0; start2 = 1'b0;
        rst = 1'b0;
        check("reset_rpc1", {ready1, busy1, done1, sen1, xen1, corr1, round1, constant1}, {1'b1, 5'd0, 6'd0, 6'd0});
        check("reset_rpc2", {ready2, busy2, done2, sen2, xen2, corr2, round2, constant2}, {1'b1, 5'd0, 6'd0, 12'd0});
        mon_on = 1'b1;

        // RPC=1 call with counter correction requested.
        push1();
        start1 = 1'b1; cc1 = 1'b1;
        run_dut(1, 43, 1, 0);
        check("a_done_latency", t_done, 42);
        check("a_done_count", n_done, 1);
        check("a_round_cycles", n_sen, 40);
        check("a_corr_cycles", n_corr, 1);
        check("a_ready_early", n_early, 0);
        check("a_ready_after", {31'd0, r_last}, 1);
        check("a_first_const", first_c, 12'h001);
        check("a_last_const", last_c, 12'h01A);
        check("a_queue_empty", exp_q1.size(), 0);

        // RPC=2 call.
        push2();
        start2 = 1'b1;
        run_dut(2, 23, 1, 0);
        check("b_done_latency", t_done, 22);
        check("b_round_cycles", n_sen, 20);
        check("b_first_const", first_c, 12'h0C1);
        check("b_last_const", last_c, 12'h6AD);
        check("b_ready_after", {31'd0, r_last}, 1);
        check("b_queue_empty", exp_q2.size(), 0);

        // Second RPC=1 call without correction.
        push1();
        start1 = 1'b1; cc1 = 1'b0;
        run_dut(1, 43, 1, 0);
        check("c_corr_cycles", n_corr, 0);
        check("c_done_latency", t_done, 42);

        // start pulsed mid-ROUND must be ignored.
        push1();
        start1 = 1'b1;
        run_dut(1, 50, 1, 10);
        check("d_done_count", n_done, 1);
        check("d_done_latency", t_done, 42);
        check("d_ready_early", n_early, 0);
        check("d_round_cycles", n_sen, 40);
        check("d_queue_empty", exp_q1.size(), 0);

        // Reset during ROUND aborts without done.
        push1();
        start1 = 1'b1;
        run_dut(1, 21, 1, 0);
        check("e_busy_before_rst", {31'd0, busy1}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("e_after_rst", {ready1, busy1, done1, sen1, xen1, yen1, zen1, round1}, {1'b1, 6'd0, 6'd0});
        check("e_no_done", n_done, 0);
        exp_q1.delete();
        tick();
        check("e_still_no_done", {31'd0, done1}, 0);
        push1();
        start1 = 1'b1;
        run_dut(1, 43, 1, 0);
        check("e_restart_first", first_c, 12'h001);
        check("e_restart_done", t_done, 42);

        // start held high: back-to-back calls.
        repeat (3) push1();
        start1 = 1'b1;
        run_dut(1, 140, 100, 0);
        check("f_done_count", n_done, 3);
        if (done_t.size() == 3) begin
            check("f_done0", done_t[0], 42);
            check("f_done1", done_t[1], 85);
            check("f_done2", done_t[2], 128);
        end else begin
            check("f_done_list_size", done_t.size(), 3);
        end
        check("f_queue_empty", exp_q1.size(), 0);

        tick();
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/romulus_tbc_sequencer.md
ROMULUS_TBC_SEQUENCER -- requirements
Module: romulus_tbc_sequencer

Interface
REQ-001 SHALL have parameter ROUNDS, default 40: SKINNY-128-384+ round count per TBC call.
REQ-002 SHALL have parameter RPC, default 1: rounds per clock, legal 1 or 2; ROUNDS divisible by RPC.
REQ-003 SHALL have port clk  in  1: clock.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1: request one TBC call.
REQ-006 SHALL have port cnt_corr  in  1: correction uses the counter-increment path; sampled with start.
REQ-007 SHALL have port ready  out  1: high in IDLE only.
REQ-008 SHALL have port busy  out  1: high in ROUND or CORRECT.
REQ-009 SHALL have port done  out  1: one-cycle completion pulse.
REQ-010 SHALL have port constant  out  6*RPC: round constants for the current cycle.
REQ-011 SHALL have ports sen, senc, xen, xenc, yen, yenc, zen, zenc  out  1 each: datapath register enables and TBC selects.
REQ-012 SHALL have port correct_cnt  out  1: counter correction select.
REQ-013 SHALL have port round  out  6: index of the first round in the current cycle.

Function
REQ-014 SHALL implement FSM states IDLE, ROUND, CORRECT, DONE.
REQ-015 IDLE: start=1 SHALL go to ROUND next cycle, latch cnt_corr, set round=0 and the rc register to 6'h01.
REQ-016 start SHALL be ignored outside IDLE.
REQ-017 ROUND SHALL assert sen=senc=xen=xenc=yen=yenc=zen=zenc=1 for exactly ROUNDS/RPC cycles.
REQ-018 rc update SHALL be rc_next = {rc[4:0], rc[5]^rc[4]^1}.
REQ-019 constant[5:0] SHALL carry the rc of round `round`; when RPC=2, constant[11:6] SHALL carry the rc of round+1.
REQ-020 Each ROUND cycle SHALL advance rc by RPC steps and round by RPC.
REQ-021 After the last ROUND cycle (round = ROUNDS-RPC) the FSM SHALL enter CORRECT.
REQ-022 CORRECT SHALL last one cycle, with xen=yen=zen=1, all *enc=0, sen=0, and correct_cnt = latched cnt_corr.
REQ-023 DONE SHALL last one cycle, with done=1 and all enables 0, then return to IDLE.
REQ-024 Latency SHALL be: start accepted in cycle T, ROUND cycles T+1..T+ROUNDS/RPC, CORRECT at T+ROUNDS/RPC+1, done at T+ROUNDS/RPC+2, ready again the cycle after.
REQ-025 Outside ROUND and CORRECT, all enables, correct_cnt and constant SHALL be 0.
REQ-026 round SHALL be 0 outside ROUND.
REQ-027 start held high through DONE SHALL be accepted in the IDLE cycle that follows, with no gap cycle inserted.

Reset
REQ-028 rst SHALL force IDLE, with rc=0, round=0, latched cnt_corr=0 and all outputs 0 except ready=1, from the next edge.
REQ-029 rst mid-ROUND or mid-CORRECT SHALL abort the call with no done pulse; rst SHALL take priority over start.

Structure
REQ-030 The state encoding, the rc LFSR step function and the ROUNDS default SHALL be defined in the shared package romulus_pkg.
REQ-031 The rc generator SHALL be a sub-module romulus_rc_lfsr (6-bit register, RPC-step combinational advance).
REQ-032 All outputs SHALL be registered or decoded from state only, with no combinational path from start.

Verification
REQ-033 Reset then start=1 with RPC=1 -> constant sequence 01,03,07,0F,1F,3E,3D,3B,... and 40th value 1A; done exactly 42 cycles after start.
REQ-034 RPC=2 -> 20 ROUND cycles; first constant 12'h0C1 ({03,01}); last constant {1A,2D}; done at cycle 22.
REQ-035 cnt_corr=1 at start, then 0 during the run -> correct_cnt=1 in the CORRECT cycle only; a second call with cnt_corr=0 -> correct_cnt stays 0.
REQ-036 start pulsed at ROUND cycle 10 -> ignored; exactly one done; ready stays low until after done.
REQ-037 rst at ROUND cycle 20 -> next cycle IDLE, ready=1, all enables 0, no done; a new start restarts at rc=01.
REQ-038 start held high continuously -> back-to-back calls, done every 43 cycles (RPC=1), enables never asserted in DONE/IDLE.
